// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, branch redirect, halt and stall handling.
// Optional FETCH_CYCLE_CNT_EN adds a saturating RUN-cycle counter on CYCLE_COUNT.
module fetch_unit (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [9:0]  START_ADDR,
  input  logic [8:0]  INSTR_IN,
  input  logic        BRANCH,
  input  logic        BRANCH_TAKEN,
  input  logic [9:0]  BR_TARGET,
  input  logic        HALT,
  input  logic        STALL,
  output logic [9:0]  PC,
  output logic [8:0]  OPCODE,
  output logic        VALID,
  output logic        DONE
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0] CYCLE_COUNT
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [8:0]  opcode_q, opcode_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic        start_fire;
  logic        halt_fire;
  logic        redirect_fire;

  // Control inputs only mean something while OPCODE carries a live instruction.
  assign halt_fire     = valid_q & HALT;
  assign redirect_fire = valid_q & BRANCH & BRANCH_TAKEN;
  assign start_fire    = ~STALL & START & (state_q != StRun);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    valid_d  = valid_q;
    done_d   = done_q;
    if (!STALL) begin
      unique case (state_q)
        StIdle, StHalted: begin
          if (START) begin
            state_d = StRun;
            pc_d    = START_ADDR;
            valid_d = 1'b0;
            done_d  = 1'b0;
          end
        end
        StRun: begin
          if (halt_fire) begin
            // Halt outranks a simultaneous redirect; PC stays on the squashed fetch.
            state_d  = StHalted;
            valid_d  = 1'b0;
            opcode_d = '0;
            done_d   = 1'b1;
          end else if (redirect_fire) begin
            pc_d     = BR_TARGET;
            valid_d  = 1'b0;
            opcode_d = '0;
          end else begin
            opcode_d = INSTR_IN;
            valid_d  = 1'b1;
            pc_d     = pc_q + 10'd1;
          end
        end
        default: begin
          state_d  = StIdle;
          pc_d     = '0;
          opcode_d = '0;
          valid_d  = 1'b0;
          done_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      opcode_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign PC     = pc_q;
  assign OPCODE = opcode_q;
  assign VALID  = valid_q;
  assign DONE   = done_q;

`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  // Every cycle spent in RUN counts, stalled or not; HALTED simply stops counting.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (start_fire) begin
      cycle_cnt_d = '0;
    end else if ((state_q == StRun) && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign CYCLE_COUNT = cycle_cnt_q;
`endif

endmodule
